// File: rtl/cmul_seq32_if.sv
// Handshake and operand/result bundle for cmul_seq32.
interface cmul_seq32_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] a_re;
    logic signed [31:0] a_im;
    logic signed [31:0] b_re;
    logic signed [31:0] b_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [64:0] p_re;
    logic signed [64:0] p_im;
    logic               busy;

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, out_ready,
        output in_ready, out_valid, p_re, p_im, busy
    );

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, out_ready,
        input  in_ready, out_valid, p_re, p_im, busy
    );
endinterface

// File: rtl/cmul_seq32.sv
// Sequential signed complex multiplier sharing one vedic32 over four product steps.
// Optional macro CMUL_MREG_EN registers the vedic32 product and adds a DRAIN state.
module vedic32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic [31:0] w_ll, w_lh, w_hl, w_hh;

    // Vertically-and-crosswise split into four 16x16 partial products
    assign w_ll = {16'b0, a[15:0]}  * {16'b0, b[15:0]};
    assign w_lh = {16'b0, a[15:0]}  * {16'b0, b[31:16]};
    assign w_hl = {16'b0, a[31:16]} * {16'b0, b[15:0]};
    assign w_hh = {16'b0, a[31:16]} * {16'b0, b[31:16]};
    assign p = {32'b0, w_ll} + {16'b0, w_lh, 16'b0} + {16'b0, w_hl, 16'b0} + {w_hh, 32'b0};
endmodule

module cmul_seq32 (
    input  logic          clk,
    input  logic          rst_n,
    cmul_seq32_if.slave   bus
);
`ifdef CMUL_MREG_EN
    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE, S_DRAIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE} state_t;
`endif

    state_t r_state, w_next;

    logic signed [31:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [64:0] r_acc_re, r_acc_im;
    logic signed [31:0] w_x, w_y;
    logic [63:0]        w_umul;
    logic signed [64:0] w_prod_s, w_acc_src;
    logic               w_accept, w_acc_en;
    logic [1:0]         w_acc_step;

    function automatic logic [31:0] mag(input logic signed [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic signed [64:0] apply_sign(input logic [63:0] m, input logic neg);
        logic signed [64:0] v;
        v = $signed({1'b0, m});
        return neg ? -v : v;
    endfunction

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_M0;
            S_M0:    w_next = S_M1;
            S_M1:    w_next = S_M2;
            S_M2:    w_next = S_M3;
`ifdef CMUL_MREG_EN
            S_M3:    w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
`else
            S_M3:    w_next = S_DONE;
`endif
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.busy      = (r_state != S_IDLE);
        w_x = '0;
        w_y = '0;
        case (r_state)
            S_M0: begin w_x = r_a_re; w_y = r_b_re; end
            S_M1: begin w_x = r_a_im; w_y = r_b_im; end
            S_M2: begin w_x = r_a_re; w_y = r_b_im; end
            S_M3: begin w_x = r_a_im; w_y = r_b_re; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_re <= bus.a_re;
            r_a_im <= bus.a_im;
            r_b_re <= bus.b_re;
            r_b_im <= bus.b_im;
        end
    end

    vedic32 u_vedic (.a(mag(w_x)), .b(mag(w_y)), .p(w_umul));

    assign w_prod_s = apply_sign(w_umul, w_x[31] ^ w_y[31]);

`ifdef CMUL_MREG_EN
    logic signed [64:0] r_prod_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prod_p0 <= '0;
        else        r_prod_p0 <= w_prod_s;
    end

    // Accumulation trails the multiply by one step
    always_comb begin
        w_acc_src  = r_prod_p0;
        w_acc_en   = 1'b1;
        w_acc_step = 2'd0;
        case (r_state)
            S_M1:    w_acc_step = 2'd0;
            S_M2:    w_acc_step = 2'd1;
            S_M3:    w_acc_step = 2'd2;
            S_DRAIN: w_acc_step = 2'd3;
            default: w_acc_en = 1'b0;
        endcase
    end
`else
    always_comb begin
        w_acc_src  = w_prod_s;
        w_acc_en   = 1'b1;
        w_acc_step = 2'd0;
        case (r_state)
            S_M0:    w_acc_step = 2'd0;
            S_M1:    w_acc_step = 2'd1;
            S_M2:    w_acc_step = 2'd2;
            S_M3:    w_acc_step = 2'd3;
            default: w_acc_en = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (w_accept) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (w_acc_en) begin
            case (w_acc_step)
                2'd0: r_acc_re <= w_acc_src;
                2'd1: r_acc_re <= r_acc_re - w_acc_src;
                2'd2: r_acc_im <= w_acc_src;
                2'd3: r_acc_im <= r_acc_im + w_acc_src;
                default: ;
            endcase
        end
    end

    assign bus.p_re = r_acc_re;
    assign bus.p_im = r_acc_im;
endmodule

// File: tb/tb_cmul_seq32.sv
// Self-checking bench for cmul_seq32 against a plain-arithmetic complex product model.
module tb_cmul_seq32;
`ifdef CMUL_MREG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    cmul_seq32_if bus ();

    cmul_seq32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic signed [64:0] m_re(input logic signed [31:0] ar, ai, br, bi);
        logic signed [64:0] xr, xi, yr, yi;
        xr = ar; xi = ai; yr = br; yi = bi;
        return xr * yr - xi * yi;
    endfunction

    function automatic logic signed [64:0] m_im(input logic signed [31:0] ar, ai, br, bi);
        logic signed [64:0] xr, xi, yr, yi;
        xr = ar; xi = ai; yr = br; yi = bi;
        return xr * yi + xi * yr;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0: return 32'h8000_0000;
            1: return 32'h7fff_ffff;
            2: return 32'h0;
            3: return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic signed [31:0] ar, ai, br, bi,
                          input logic [64:0] exp_re, exp_im, input bit hold);
        int cyc;
        bus.out_ready = !hold;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin tick(); cyc++; end
        bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin tick(); cyc++; end
        chk({tag, "_lat"}, 65'(cyc), 65'(LAT));
        chk({tag, "_re"}, bus.p_re, exp_re);
        chk({tag, "_im"}, bus.p_im, exp_im);
        chk({tag, "_busy"}, 65'(bus.busy), 65'd1);
        chk({tag, "_inrdy"}, 65'(bus.in_ready), 65'd0);
        if (!hold) begin
            tick();
            chk({tag, "_idle"}, 65'(bus.in_ready), 65'd1);
        end
    endtask

    task automatic stream(input string tag, input int n, input bit rand_ready, input bit chk_space);
        logic [64:0] qre[$];
        logic [64:0] qim[$];
        int sent, got, cyc, last;
        sent = 0; got = 0; cyc = 0; last = -1;
        while (got < n && cyc < n * 20 + 100) begin
            bus.out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (qre.size() == 0) chk({tag, "_spurious"}, 65'd1, 65'd0);
                else begin
                    chk({tag, "_re"}, bus.p_re, qre.pop_front());
                    chk({tag, "_im"}, bus.p_im, qim.pop_front());
                end
                if (chk_space && last >= 0) chk({tag, "_space"}, 65'(cyc - last), 65'(LAT + 2));
                last = cyc;
                got++;
            end
            if (sent < n) begin
                bus.a_re = rnd32(); bus.a_im = rnd32(); bus.b_re = rnd32(); bus.b_im = rnd32();
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    qre.push_back(m_re(bus.a_re, bus.a_im, bus.b_re, bus.b_im));
                    qim.push_back(m_im(bus.a_re, bus.a_im, bus.b_re, bus.b_im));
                    sent++;
                end
            end else bus.in_valid = 1'b0;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_count"}, 65'(got), 65'(n));
    endtask

    initial begin
        logic [64:0] hold_re, hold_im;
        int seen;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
        tick(); tick();
        chk("rst_inrdy", 65'(bus.in_ready), 65'd1);
        chk("rst_ovld", 65'(bus.out_valid), 65'd0);
        chk("rst_busy", 65'(bus.busy), 65'd0);
        chk("rst_pre", bus.p_re, 65'd0);
        chk("rst_pim", bus.p_im, 65'd0);
        rst_n = 1'b1;
        tick();

        run_op("basic", 32'sd3, 32'sd4, 32'sd5, 32'sd6, -65'sd9, 65'sd38, 1'b0);
        run_op("minall", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
               65'd0, 65'h0_8000_0000_0000_0000, 1'b0);
        run_op("maxmin", 32'h7fff_ffff, 32'sd0, 32'h8000_0000, 32'sd0,
               -65'sd4611686016279904256, 65'd0, 1'b0);

        // Backpressure: hold DONE while hammering the input side
        run_op("bp", -32'sd123456, 32'sd777, 32'sd99999, -32'sd31,
               m_re(-32'sd123456, 32'sd777, 32'sd99999, -32'sd31),
               m_im(-32'sd123456, 32'sd777, 32'sd99999, -32'sd31), 1'b1);
        hold_re = bus.p_re; hold_im = bus.p_im;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom % 2);
            bus.a_re = rnd32(); bus.a_im = rnd32(); bus.b_re = rnd32(); bus.b_im = rnd32();
            tick();
            chk("bp_re", bus.p_re, hold_re);
            chk("bp_im", bus.p_im, hold_im);
            chk("bp_ovld", 65'(bus.out_valid), 65'd1);
            chk("bp_inrdy", 65'(bus.in_ready), 65'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_inrdy", 65'(bus.in_ready), 65'd1);
        chk("bp_release_ovld", 65'(bus.out_valid), 65'd0);

        stream("b2b", 3, 1'b0, 1'b1);

        // Asynchronous reset while in M2
        bus.a_re = 32'sd1000; bus.a_im = -32'sd7; bus.b_re = 32'sd300; bus.b_im = 32'sd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("m2_pre_nonzero", 65'(bus.p_re != 65'd0), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_pre", bus.p_re, 65'd0);
        chk("arst_pim", bus.p_im, 65'd0);
        chk("arst_busy", 65'(bus.busy), 65'd0);
        chk("arst_inrdy", 65'(bus.in_ready), 65'd1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("abort_no_ovld", 65'(seen), 65'd0);
        chk("abort_inrdy", 65'(bus.in_ready), 65'd1);

        stream("rand", 4000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
